// File: rtl/ext_irq_ctl.sv
// External interrupt controller: synchronizes Channels request lines, arbitrates by
// priority/threshold and drives a registered exti. Edge mode is built with EXT_IRQ_CTL__EDGE_EN.
module ext_irq_ctl #(
    parameter int Channels  = 8,
    parameter int PrioWidth = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [Channels-1:0] irq_src,
    input  logic [5:0]          reg_addr,
    input  logic                reg_rd,
    input  logic                reg_wr,
    input  logic [31:0]         reg_wdata,
    output logic [31:0]         reg_rdata,
    output logic                exti
);

    localparam int IdW = 5;

    localparam logic [5:0] AddrEnable    = 6'd0;
    localparam logic [5:0] AddrPending   = 6'd1;
    localparam logic [5:0] AddrInservice = 6'd2;
    localparam logic [5:0] AddrThreshold = 6'd3;
    localparam logic [5:0] AddrClaim     = 6'd4;
    localparam logic [5:0] AddrMode      = 6'd5;
    localparam int         PrioBase      = 8;

    logic [Channels-1:0]  sync1;
    logic [Channels-1:0]  sync2;
    logic [Channels-1:0]  enable;
    logic [Channels-1:0]  inservice;
    logic [Channels-1:0]  pending;
    logic [Channels-1:0]  eligible;
    logic [Channels-1:0]  win_oh;
    logic [Channels-1:0]  claim_mask;
    logic [Channels-1:0]  complete_mask;
    logic [PrioWidth-1:0] threshold;
    logic [PrioWidth-1:0] prio [Channels];
    logic [PrioWidth-1:0] best_prio;
    logic [IdW-1:0]       win_id;
    logic [31:0]          rdata_n;
    logic                 claim;

    // A read colliding with a write is dropped entirely, so CLAIM only fires on a lone read.
    assign claim = reg_rd && !reg_wr && (reg_addr == AddrClaim);

`ifdef EXT_IRQ_CTL__EDGE_EN
    logic [Channels-1:0] mode;
    logic [Channels-1:0] mode_n;
    logic [Channels-1:0] sync3;
    logic [Channels-1:0] edge_pend;
    logic [Channels-1:0] rise;

    assign mode_n  = (reg_wr && reg_addr == AddrMode) ? reg_wdata[Channels-1:0] : mode;
    assign rise    = sync2 & ~sync3;
    assign pending = (mode & edge_pend) | (~mode & sync2);

    // A fresh edge wins over a same-cycle claim; clearing a MODE bit drops its latched edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode      <= '0;
            sync3     <= '0;
            edge_pend <= '0;
        end else begin
            mode      <= mode_n;
            sync3     <= sync2;
            edge_pend <= ((edge_pend & ~claim_mask) | (rise & mode)) & mode_n;
        end
    end
`else
    assign pending = sync2;
`endif

    always_comb begin
        for (int i = 0; i < Channels; i++) begin
            eligible[i] = pending[i] & enable[i] & ~inservice[i] & (prio[i] > threshold);
        end
    end

    // Strict '>' keeps the lowest id on priority ties; eligible implies priority >= 1.
    always_comb begin
        win_oh    = '0;
        win_id    = '0;
        best_prio = '0;
        for (int i = 0; i < Channels; i++) begin
            if (eligible[i] && (prio[i] > best_prio)) begin
                best_prio = prio[i];
                win_id    = IdW'(i + 1);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    assign claim_mask = claim ? win_oh : '0;

    always_comb begin
        for (int i = 0; i < Channels; i++) begin
            complete_mask[i] = reg_wr && (reg_addr == AddrClaim) && (reg_wdata == 32'(i + 1));
        end
    end

    always_comb begin
        rdata_n = '0;
        case (reg_addr)
            AddrEnable:    rdata_n = 32'(enable);
            AddrPending:   rdata_n = 32'(pending);
            AddrInservice: rdata_n = 32'(inservice);
            AddrThreshold: rdata_n = 32'(threshold);
            AddrClaim:     rdata_n = 32'(win_id);
`ifdef EXT_IRQ_CTL__EDGE_EN
            AddrMode:      rdata_n = 32'(mode);
`endif
            default:       rdata_n = '0;
        endcase
        for (int i = 0; i < Channels; i++) begin
            if (reg_addr == 6'(PrioBase + i)) begin
                rdata_n = 32'(prio[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            enable    <= '0;
            inservice <= '0;
            threshold <= '0;
            reg_rdata <= '0;
            exti      <= 1'b0;
            for (int i = 0; i < Channels; i++) begin
                prio[i] <= '0;
            end
        end else begin
            sync1 <= irq_src;
            sync2 <= sync1;
            if (reg_wr && reg_addr == AddrEnable) begin
                enable <= reg_wdata[Channels-1:0];
            end
            if (reg_wr && reg_addr == AddrThreshold) begin
                threshold <= reg_wdata[PrioWidth-1:0];
            end
            for (int i = 0; i < Channels; i++) begin
                if (reg_wr && reg_addr == 6'(PrioBase + i)) begin
                    prio[i] <= reg_wdata[PrioWidth-1:0];
                end
            end
            inservice <= (inservice | claim_mask) & ~complete_mask;
            exti      <= |eligible;
            if (reg_rd) begin
                reg_rdata <= reg_wr ? '0 : rdata_n;
            end
        end
    end

endmodule

// File: tb/tb_ext_irq_ctl.sv
// Self-checking bench for ext_irq_ctl: register reads are scored through an expected queue;
// exti is checked directly at the falling edge.
module tb_ext_irq_ctl;

    localparam int Channels  = 8;
    localparam int PrioWidth = 3;

    logic                clk;
    logic                rst_n;
    logic [Channels-1:0] irq_src;
    logic [5:0]          reg_addr;
    logic                reg_rd;
    logic                reg_wr;
    logic [31:0]         reg_wdata;
    logic [31:0]         reg_rdata;
    logic                exti;

    int n_checks;
    int n_errors;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        rd_d;

    ext_irq_ctl #(.Channels(Channels), .PrioWidth(PrioWidth)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_src   (irq_src),
        .reg_addr  (reg_addr),
        .reg_rd    (reg_rd),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .exti      (exti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: every read strobe seen by the DUT is matched against the queued expectation.
    always @(posedge clk) rd_d <= reg_rd && rst_n;

    always @(negedge clk) begin
        if (rd_d) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                check(tag_q.pop_front(), reg_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic reg_write(input logic [5:0] addr, input logic [31:0] data);
        @(negedge clk);
        reg_addr  = addr;
        reg_wdata = data;
        reg_wr    = 1'b1;
        @(negedge clk);
        reg_wr    = 1'b0;
    endtask

    task automatic reg_read(input string tag, input logic [5:0] addr, input logic [31:0] exp);
        @(negedge clk);
        reg_addr = addr;
        reg_rd   = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        reg_rd   = 1'b0;
    endtask

    task automatic reg_rd_wr(input string tag, input logic [5:0] addr, input logic [31:0] data);
        @(negedge clk);
        reg_addr  = addr;
        reg_wdata = data;
        reg_rd    = 1'b1;
        reg_wr    = 1'b1;
        exp_q.push_back(32'd0);
        tag_q.push_back(tag);
        @(negedge clk);
        reg_rd    = 1'b0;
        reg_wr    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_exti(input string tag, input logic val, input int max_cycles);
        int n;
        n = 0;
        while (exti !== val && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exti), 32'(val));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        irq_src   = '0;
        reg_addr  = '0;
        reg_rd    = 1'b0;
        reg_wr    = 1'b0;
        reg_wdata = '0;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        check("reset_exti", 32'(exti), 32'd0);
        check("reset_rdata", reg_rdata, 32'd0);
        for (int a = 0; a < 6; a++) reg_read("reset_reg", 6'(a), 32'd0);
        reg_read("reset_prio0", 6'd8, 32'd0);
        reg_read("unmapped_6", 6'd6, 32'd0);
        reg_read("unmapped_16", 6'd16, 32'd0);

        // Basic request: id 3 at priority 3 above threshold 1.
        reg_write(6'd0, 32'hFFFF_FFFF);
        reg_write(6'd10, 32'hFFFF_FFFB);
        reg_write(6'd3, 32'd1);
        reg_read("enable_rd", 6'd0, 32'h0000_00FF);
        reg_read("prio2_rd", 6'd10, 32'd3);
        reg_read("thresh_rd", 6'd3, 32'd1);
`ifndef EXT_IRQ_CTL__EDGE_EN
        reg_write(6'd5, 32'hFF);
        reg_read("mode_absent", 6'd5, 32'd0);
`endif
        @(negedge clk);
        irq_src[2] = 1'b1;
        wait_exti("exti_latency", 1'b1, 4);
        reg_read("claim_id3", 6'd4, 32'd3);
        reg_read("insvc_after_claim", 6'd2, 32'h04);
        check("exti_drop_after_claim", 32'(exti), 32'd0);

        // Invalid completes leave INSERVICE alone; a valid one re-arms the still-high level source.
        reg_write(6'd4, 32'd0);
        reg_write(6'd4, 32'd9);
        reg_write(6'd4, 32'd5);
        reg_read("insvc_bad_complete", 6'd2, 32'h04);
        reg_write(6'd4, 32'd3);
        check("exti_before_rearm", 32'(exti), 32'd0);
        @(negedge clk);
        check("exti_rearm", 32'(exti), 32'd1);
        reg_read("insvc_cleared", 6'd2, 32'h00);
        reg_read("claim_id3_again", 6'd4, 32'd3);
        irq_src[2] = 1'b0;
        idle(4);
        reg_write(6'd4, 32'd3);
        idle(2);
        check("exti_idle", 32'(exti), 32'd0);

        // Priority ordering with a tie between ids 2 and 5.
        reg_write(6'd9, 32'd4);
        reg_write(6'd12, 32'd4);
        reg_write(6'd14, 32'd6);
        @(negedge clk);
        irq_src = 8'b0101_0010;
        idle(4);
        reg_read("pending_3ch", 6'd1, 32'h52);
        reg_read("claim_id7", 6'd4, 32'd7);
        reg_read("claim_id2", 6'd4, 32'd2);
        reg_read("claim_id5", 6'd4, 32'd5);
        reg_read("insvc_nested", 6'd2, (32'd1 << 1) | (32'd1 << 4) | (32'd1 << 6));
        reg_read("claim_none", 6'd4, 32'd0);
        check("exti_all_served", 32'(exti), 32'd0);
        irq_src = '0;
        idle(4);
        reg_write(6'd4, 32'd7);
        reg_write(6'd4, 32'd2);
        reg_write(6'd4, 32'd5);
        reg_read("insvc_all_done", 6'd2, 32'd0);

        // Priority equal to threshold is not eligible; lowering the threshold releases it.
        reg_write(6'd8, 32'd2);
        reg_write(6'd3, 32'd2);
        @(negedge clk);
        irq_src[0] = 1'b1;
        idle(6);
        check("exti_at_threshold", 32'(exti), 32'd0);
        reg_write(6'd3, 32'd1);
        check("exti_thresh_1cyc", 32'(exti), 32'd0);
        @(negedge clk);
        check("exti_thresh_2cyc", 32'(exti), 32'd1);
        reg_rd_wr("rdwr_claim_zero", 6'd4, 32'd0);
        reg_read("insvc_no_side_effect", 6'd2, 32'd0);
        reg_read("claim_id1", 6'd4, 32'd1);

        // Reset while a request is active and a channel is in service.
        @(negedge clk);
        irq_src[2] = 1'b1;
        wait_exti("exti_before_reset", 1'b1, 4);
        @(negedge clk);
        rst_n   = 1'b0;
        irq_src = '0;
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_mid_exti", 32'(exti), 32'd0);
        for (int a = 0; a < 6; a++) reg_read("reset_mid_reg", 6'(a), 32'd0);
        reg_read("reset_mid_prio0", 6'd8, 32'd0);
        reg_read("reset_mid_prio2", 6'd10, 32'd0);
        check("reset_mid_exti_late", 32'(exti), 32'd0);

`ifdef EXT_IRQ_CTL__EDGE_EN
        // Edge channel latches a short pulse until claimed or its MODE bit is cleared.
        reg_write(6'd0, 32'h02);
        reg_write(6'd9, 32'd2);
        reg_write(6'd5, 32'h02);
        reg_read("mode_rd", 6'd5, 32'h02);
        @(negedge clk);
        irq_src[1] = 1'b1;
        idle(3);
        irq_src[1] = 1'b0;
        idle(6);
        reg_read("edge_pending", 6'd1, 32'h02);
        check("edge_exti", 32'(exti), 32'd1);
        reg_read("edge_claim", 6'd4, 32'd2);
        reg_read("edge_pending_clr", 6'd1, 32'h00);
        reg_write(6'd4, 32'd2);
        irq_src[1] = 1'b1;
        idle(3);
        irq_src[1] = 1'b0;
        idle(6);
        reg_read("edge_pending2", 6'd1, 32'h02);
        reg_write(6'd5, 32'h00);
        reg_read("edge_mode_clear", 6'd1, 32'h00);
`endif

        idle(3);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
